// File: rtl/n64_vbus_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | n64_vbus_demux: splits the N64 sync/R/G/B video bus and classifies fields |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module n64_vbus_demux #(
  parameter int         color_width_i   = 7,
  parameter logic [9:0] pal_line_thresh = 10'd290
) (
  input  logic                     N64_CLK_i,
  input  logic                     N64_VRST_i,
  input  logic                     nVDSYNC_i,
  input  logic [color_width_i-1:0] VD_i,
  output logic [3:0]               sync_o,
  output logic [color_width_i-1:0] R_o,
  output logic [color_width_i-1:0] G_o,
  output logic [color_width_i-1:0] B_o,
  output logic                     vdata_valid_o,
  output logic                     phase_err_o,
  output logic [9:0]               line_cnt_o,
  output logic                     pal_o,
  output logic                     interlaced_o,
  output logic                     field_o
);

  localparam logic [1:0] c_ph_red  = 2'd0;
  localparam logic [1:0] c_ph_grn  = 2'd1;
  localparam logic [1:0] c_ph_blu  = 2'd2;
  localparam logic [1:0] c_ph_idle = 2'd3;
  localparam logic [9:0] c_ctr_max = 10'h3FF;

  logic [1:0]               r_phase;
  logic [3:0]               r_sync;
  logic [color_width_i-1:0] r_red;
  logic [color_width_i-1:0] r_grn;
  logic [9:0]               r_line_ctr;
  logic                     w_hs_fall;
  logic                     w_vs_fall;

  // Edges are judged between the previous and the incoming sync word.
  assign w_hs_fall = ~nVDSYNC_i & r_sync[1] & ~VD_i[1];
  assign w_vs_fall = ~nVDSYNC_i & r_sync[3] & ~VD_i[3];

  always_ff @(posedge N64_CLK_i or posedge N64_VRST_i) begin
    if (N64_VRST_i) begin
      r_phase       <= c_ph_idle;
      r_sync        <= 4'hF;
      r_red         <= '0;
      r_grn         <= '0;
      sync_o        <= 4'hF;
      R_o           <= '0;
      G_o           <= '0;
      B_o           <= '0;
      vdata_valid_o <= 1'b0;
      phase_err_o   <= 1'b0;
    end else begin
      vdata_valid_o <= 1'b0;
      phase_err_o   <= 1'b0;
      if (!nVDSYNC_i) begin
        r_phase <= c_ph_red;
        r_sync  <= VD_i[3:0];
        // A sync word arriving after R or G but before B truncates the pixel.
        if ((r_phase == c_ph_grn) || (r_phase == c_ph_blu)) begin
          phase_err_o <= 1'b1;
        end
      end else begin
        case (r_phase)
          c_ph_red: begin
            r_red   <= VD_i;
            r_phase <= c_ph_grn;
          end
          c_ph_grn: begin
            r_grn   <= VD_i;
            r_phase <= c_ph_blu;
          end
          c_ph_blu: begin
            R_o           <= r_red;
            G_o           <= r_grn;
            B_o           <= VD_i;
            sync_o        <= r_sync;
            vdata_valid_o <= 1'b1;
            r_phase       <= c_ph_idle;
          end
          default: begin
            r_phase <= c_ph_idle;
          end
        endcase
      end
    end
  end

  always_ff @(posedge N64_CLK_i or posedge N64_VRST_i) begin
    if (N64_VRST_i) begin
      r_line_ctr   <= '0;
      line_cnt_o   <= '0;
      pal_o        <= 1'b0;
      interlaced_o <= 1'b0;
      field_o      <= 1'b0;
    end else if (w_vs_fall) begin
      line_cnt_o   <= r_line_ctr;
      pal_o        <= (r_line_ctr >= pal_line_thresh);
      r_line_ctr   <= w_hs_fall ? 10'd1 : 10'd0;
      field_o      <= VD_i[1];
      interlaced_o <= (VD_i[1] != field_o);
    end else if (w_hs_fall && (r_line_ctr != c_ctr_max)) begin
      r_line_ctr <= r_line_ctr + 10'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_n64_vbus_demux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_n64_vbus_demux: self-checking bench with a word-stream reference model |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_n64_vbus_demux;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         nv  = 1'b1;
  logic [W-1:0] vd  = '0;

  logic [3:0]   sync_o;
  logic [W-1:0] R_o, G_o, B_o;
  logic         vdata_valid_o, phase_err_o;
  logic [9:0]   line_cnt_o;
  logic         pal_o, interlaced_o, field_o;

  n64_vbus_demux #(.color_width_i(W), .pal_line_thresh(10'd290)) dut (
    .N64_CLK_i     (clk),
    .N64_VRST_i    (rst),
    .nVDSYNC_i     (nv),
    .VD_i          (vd),
    .sync_o        (sync_o),
    .R_o           (R_o),
    .G_o           (G_o),
    .B_o           (B_o),
    .vdata_valid_o (vdata_valid_o),
    .phase_err_o   (phase_err_o),
    .line_cnt_o    (line_cnt_o),
    .pal_o         (pal_o),
    .interlaced_o  (interlaced_o),
    .field_o       (field_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_strobe = 0;
  int n_err    = 0;

  // Reference model: words since the last sync word, plus field statistics.
  logic         have_sync;
  logic [W-1:0] grp[$];
  logic [3:0]   last_sync;
  int           hs_count;
  logic [W-1:0] e_r, e_g, e_b;
  logic [3:0]   e_sync;
  logic         e_valid, e_err;
  logic [9:0]   e_line;
  logic         e_pal, e_inter, e_field;

  task automatic model_reset();
    have_sync = 1'b0;
    grp.delete();
    last_sync = 4'hF;
    hs_count  = 0;
    e_r = '0; e_g = '0; e_b = '0; e_sync = 4'hF;
    e_valid = 1'b0; e_err = 1'b0;
    e_line = '0; e_pal = 1'b0; e_inter = 1'b0; e_field = 1'b0;
  endtask

  task automatic drive(input logic n, input logic [W-1:0] d);
    logic hs_f, vs_f;
    nv = n;
    vd = d;
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (!n) begin
      if (have_sync && (grp.size() == 1 || grp.size() == 2)) e_err = 1'b1;
      hs_f = last_sync[1] && !d[1];
      vs_f = last_sync[3] && !d[3];
      if (vs_f) begin
        e_line   = 10'(hs_count);
        e_pal    = (hs_count >= 290);
        hs_count = hs_f ? 1 : 0;
        e_inter  = (d[1] != e_field);
        e_field  = d[1];
      end else if (hs_f) begin
        hs_count = (hs_count < 1023) ? hs_count + 1 : 1023;
      end
      last_sync = d[3:0];
      have_sync = 1'b1;
      grp.delete();
    end else if (have_sync && grp.size() < 3) begin
      grp.push_back(d);
      if (grp.size() == 3) begin
        e_r = grp[0]; e_g = grp[1]; e_b = grp[2];
        e_sync  = last_sync;
        e_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (vdata_valid_o) n_strobe++;
    if (phase_err_o) n_err++;
  endtask

  // Sync-word-only field: nlines HS falls, then a VS fall with HS at hs_at_vs.
  task automatic gen_field(input int nlines, input logic hs_at_vs);
    for (int i = 0; i < nlines; i++) begin
      drive(1'b0, {3'b000, 4'b1111});
      drive(1'b0, {3'b000, 4'b1101});
    end
    drive(1'b0, {3'b000, 1'b0, 1'b1, hs_at_vs, 1'b1});
    drive(1'b0, {3'b000, 4'b1111});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nv  = 1'b0;
    vd  = W'($urandom);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({R_o, G_o, B_o, sync_o, vdata_valid_o, phase_err_o} !== {{(3*W){1'b0}}, 4'hF, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_pixel: actual %h required %h",
               {R_o, G_o, B_o, sync_o, vdata_valid_o, phase_err_o}, {{(3*W){1'b0}}, 4'hF, 2'b00});
    end
    n_cmp++;
    if ({line_cnt_o, pal_o, interlaced_o, field_o} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_status: actual %h required 0", {line_cnt_o, pal_o, interlaced_o, field_o});
    end
    nv  = 1'b1;
    rst = 1'b0;
  endtask

  task automatic test_pixel();
    drive(1'b0, 7'h7F);
    drive(1'b1, 7'h11);
    drive(1'b1, 7'h22);
    n_cmp++;
    if (vdata_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL pixel_early_valid: actual %b required 0", vdata_valid_o);
    end
    drive(1'b1, 7'h33);
    n_cmp++;
    if ({vdata_valid_o, R_o, G_o, B_o, sync_o} !== {1'b1, 7'h11, 7'h22, 7'h33, 4'hF}) begin
      n_fail++;
      $display("FAIL pixel_out: actual %h required %h",
               {vdata_valid_o, R_o, G_o, B_o, sync_o}, {1'b1, 7'h11, 7'h22, 7'h33, 4'hF});
    end
    drive(1'b1, 7'h44);
    n_cmp++;
    if ({vdata_valid_o, R_o, G_o, B_o} !== {1'b0, 7'h11, 7'h22, 7'h33}) begin
      n_fail++;
      $display("FAIL pixel_single_strobe: actual %h required %h",
               {vdata_valid_o, R_o, G_o, B_o}, {1'b0, 7'h11, 7'h22, 7'h33});
    end
  endtask

  task automatic test_phase_err();
    int s0, e0;
    s0 = n_strobe;
    e0 = n_err;
    drive(1'b0, 7'h7F);
    drive(1'b1, 7'h05);
    drive(1'b0, 7'h7F);
    n_cmp++;
    if ({phase_err_o, vdata_valid_o, R_o, G_o, B_o} !== {2'b10, 7'h11, 7'h22, 7'h33}) begin
      n_fail++;
      $display("FAIL phase_err_pulse: actual %h required %h",
               {phase_err_o, vdata_valid_o, R_o, G_o, B_o}, {2'b10, 7'h11, 7'h22, 7'h33});
    end
    drive(1'b0, 7'h7F);
    drive(1'b0, 7'h7F);
    n_cmp++;
    if ((n_err - e0) != 1 || (n_strobe - s0) != 0) begin
      n_fail++;
      $display("FAIL phase_err_count: actual err=%0d strobe=%0d required err=1 strobe=0",
               n_err - e0, n_strobe - s0);
    end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = n_strobe;
    drive(1'b0, 7'h7F);
    for (int i = 0; i < 3; i++) drive(1'b1, W'($urandom));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'($urandom));
      n_cmp++;
      if (vdata_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL gap_strobe: actual %b required 0 (gap cycle %0d)", vdata_valid_o, i);
      end
    end
    drive(1'b0, 7'h7B);
    drive(1'b1, 7'h01);
    drive(1'b1, 7'h02);
    drive(1'b1, 7'h03);
    n_cmp++;
    if ({vdata_valid_o, R_o, G_o, B_o, sync_o} !== {1'b1, 7'h01, 7'h02, 7'h03, 4'hB}) begin
      n_fail++;
      $display("FAIL second_pixel: actual %h required %h",
               {vdata_valid_o, R_o, G_o, B_o, sync_o}, {1'b1, 7'h01, 7'h02, 7'h03, 4'hB});
    end
    n_cmp++;
    if ((n_strobe - s0) != 2) begin
      n_fail++;
      $display("FAIL gap_strobe_total: actual %0d required 2", n_strobe - s0);
    end
  endtask

  task automatic test_fields();
    gen_field(0, 1'b1);
    gen_field(263, 1'b1);
    gen_field(263, 1'b1);
    n_cmp++;
    if ({line_cnt_o, pal_o, interlaced_o, field_o} !== {10'd263, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ntsc_field: actual line=%0d pal=%b int=%b fld=%b required 263/0/0/1",
               line_cnt_o, pal_o, interlaced_o, field_o);
    end
    gen_field(313, 1'b1);
    n_cmp++;
    if ({line_cnt_o, pal_o, interlaced_o, field_o} !== {10'd313, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL pal_field_a: actual line=%0d pal=%b int=%b fld=%b required 313/1/0/1",
               line_cnt_o, pal_o, interlaced_o, field_o);
    end
    gen_field(312, 1'b0);
    n_cmp++;
    if ({line_cnt_o, pal_o, interlaced_o, field_o} !== {10'd312, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL pal_field_b: actual line=%0d pal=%b int=%b fld=%b required 312/1/1/0",
               line_cnt_o, pal_o, interlaced_o, field_o);
    end
  endtask

  task automatic test_saturate();
    gen_field(1100, 1'b1);
    n_cmp++;
    if ({line_cnt_o, pal_o} !== {10'd1023, 1'b1}) begin
      n_fail++;
      $display("FAIL saturate: actual line=%0d pal=%b required 1023/1", line_cnt_o, pal_o);
    end
  endtask

  task automatic test_reset_mid();
    int s0, e0;
    drive(1'b0, 7'h7F);
    drive(1'b1, 7'h15);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({R_o, G_o, B_o, sync_o, vdata_valid_o, phase_err_o, line_cnt_o, pal_o, interlaced_o, field_o}
        !== {{(3*W){1'b0}}, 4'hF, 2'b00, 13'd0}) begin
      n_fail++;
      $display("FAIL async_reset: actual %h required %h",
               {R_o, G_o, B_o, sync_o, vdata_valid_o, phase_err_o, line_cnt_o, pal_o, interlaced_o, field_o},
               {{(3*W){1'b0}}, 4'hF, 2'b00, 13'd0});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    s0 = n_strobe;
    e0 = n_err;
    drive(1'b1, 7'h26);
    drive(1'b1, 7'h37);
    drive(1'b1, 7'h48);
    n_cmp++;
    if ((n_strobe - s0) != 0 || (n_err - e0) != 0 ||
        {R_o, G_o, B_o, sync_o} !== {{(3*W){1'b0}}, 4'hF}) begin
      n_fail++;
      $display("FAIL post_reset_ignore: actual strobe=%0d err=%0d bus=%h required 0/0/%h",
               n_strobe - s0, n_err - e0, {R_o, G_o, B_o, sync_o}, {{(3*W){1'b0}}, 4'hF});
    end
    drive(1'b0, 7'h7E);
    drive(1'b1, 7'h0A);
    drive(1'b1, 7'h0B);
    drive(1'b1, 7'h0C);
    n_cmp++;
    if ({vdata_valid_o, R_o, G_o, B_o, sync_o} !== {1'b1, 7'h0A, 7'h0B, 7'h0C, 4'hE}) begin
      n_fail++;
      $display("FAIL post_reset_pixel: actual %h required %h",
               {vdata_valid_o, R_o, G_o, B_o, sync_o}, {1'b1, 7'h0A, 7'h0B, 7'h0C, 4'hE});
    end
  endtask

  task automatic test_random();
    logic n;
    for (int i = 0; i < 4000; i++) begin
      n = ($urandom_range(0, 3) != 0);
      drive(n, W'($urandom));
      n_cmp++;
      if ({R_o, G_o, B_o, sync_o, vdata_valid_o, phase_err_o} !== {e_r, e_g, e_b, e_sync, e_valid, e_err}) begin
        n_fail++;
        $display("FAIL random_pixel cyc %0d: actual %h required %h", i,
                 {R_o, G_o, B_o, sync_o, vdata_valid_o, phase_err_o}, {e_r, e_g, e_b, e_sync, e_valid, e_err});
      end
      n_cmp++;
      if ({line_cnt_o, pal_o, interlaced_o, field_o} !== {e_line, e_pal, e_inter, e_field}) begin
        n_fail++;
        $display("FAIL random_status cyc %0d: actual %h required %h", i,
                 {line_cnt_o, pal_o, interlaced_o, field_o}, {e_line, e_pal, e_inter, e_field});
      end
    end
  endtask

  initial begin
    model_reset();
    #1;
    test_reset();
    test_pixel();
    test_phase_err();
    test_back_to_back();
    test_fields();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
